// File: rtl/bp_update_sched_if.sv
// Update/write bus of the branch-predictor update scheduler.
// The master side offers resolved branch updates and observes the PHT write
// port; the slave side (the scheduler) accepts updates and drives PHT writes.
interface bp_update_sched_if #(
    parameter int S_ROW_IDX = 4,
    parameter int S_GBHR    = 4
);
    logic                 upd_valid;
    logic [S_ROW_IDX-1:0] upd_row;
    logic [S_GBHR-1:0]    upd_col;
    logic [1:0]           upd_state;
    logic                 upd_br_en;
    logic                 upd_ready;
    logic                 tbl_we;
    logic [S_ROW_IDX-1:0] tbl_row;
    logic [S_GBHR-1:0]    tbl_col;
    logic [1:0]           tbl_wdata;

    modport master (
        output upd_valid, upd_row, upd_col, upd_state, upd_br_en,
        input  upd_ready, tbl_we, tbl_row, tbl_col, tbl_wdata
    );

    modport slave (
        input  upd_valid, upd_row, upd_col, upd_state, upd_br_en,
        output upd_ready, tbl_we, tbl_row, tbl_col, tbl_wdata
    );
endinterface

// File: rtl/bp_update_sched.sv
// Branch-predictor PHT update scheduler.
// After reset or clr the whole PHT is walked and written to weakly-not-taken.
// Resolved branch updates are buffered in a small FIFO and drained one per
// cycle once the walk is done. A one-entry bypass register forwards the value
// just written so back-to-back updates to the same counter see fresh data.
module bp_update_sched #(
    parameter int S_ROW_IDX = 4,
    parameter int S_GBHR    = 4,
    parameter int DEPTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    bp_update_sched_if.slave        bus,
    output logic                    init_busy,
    output logic                    mispred,
    output logic [15:0]             mispred_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = S_ROW_IDX + S_GBHR;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // 2-bit saturating counter step towards the actual outcome
    function automatic logic [1:0] sat_step(input logic [1:0] base, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (base == 2'd3) ? 2'd3 : base + 2'd1;
        end else begin
            res = (base == 2'd0) ? 2'd0 : base - 2'd1;
        end
        return res;
    endfunction

    state_t               state_r;
    logic [IW-1:0]        walk_r;

    logic [S_ROW_IDX-1:0] q_row_r   [DEPTH];
    logic [S_GBHR-1:0]    q_col_r   [DEPTH];
    logic [1:0]           q_state_r [DEPTH];
    logic                 q_br_r    [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;

    logic                 byp_valid_r;
    logic [S_ROW_IDX-1:0] byp_row_r;
    logic [S_GBHR-1:0]    byp_col_r;
    logic [1:0]           byp_val_r;

    logic [15:0]          cnt_r;

    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic [S_ROW_IDX-1:0] hd_row_s;
    logic [S_GBHR-1:0]    hd_col_s;
    logic [1:0]           hd_state_s;
    logic                 hd_br_s;
    logic [1:0]           base_s;
    logic [1:0]           run_wdata_s;
    logic                 mispred_s;

    // Queue status, head decode, counter update and handshake qualifiers
    always_comb begin
        full_s      = (count_r == (AW+1)'(DEPTH));
        empty_s     = (count_r == {(AW+1){1'b0}});
        push_s      = rst && !clr && bus.upd_valid && !full_s;
        pop_s       = rst && (state_r == ST_RUN) && !empty_s;
        hd_row_s    = q_row_r[rd_ptr_r];
        hd_col_s    = q_col_r[rd_ptr_r];
        hd_state_s  = q_state_r[rd_ptr_r];
        hd_br_s     = q_br_r[rd_ptr_r];
        if (byp_valid_r && (byp_row_r == hd_row_s) && (byp_col_r == hd_col_s)) begin
            base_s = byp_val_r;
        end else begin
            base_s = hd_state_s;
        end
        run_wdata_s = sat_step(base_s, hd_br_s);
        mispred_s   = pop_s && (base_s[1] != hd_br_s);
    end

    // PHT write port and status outputs; INIT writes come from the walk index
    always_comb begin
        bus.tbl_we    = 1'b0;
        bus.tbl_row   = {S_ROW_IDX{1'b0}};
        bus.tbl_col   = {S_GBHR{1'b0}};
        bus.tbl_wdata = 2'd0;
        if (!rst) begin
            bus.tbl_we = 1'b0;
        end else if (state_r == ST_INIT) begin
            bus.tbl_we    = 1'b1;
            bus.tbl_row   = walk_r[IW-1:S_GBHR];
            bus.tbl_col   = walk_r[S_GBHR-1:0];
            bus.tbl_wdata = 2'd1;
        end else if (!empty_s) begin
            bus.tbl_we    = 1'b1;
            bus.tbl_row   = hd_row_s;
            bus.tbl_col   = hd_col_s;
            bus.tbl_wdata = run_wdata_s;
        end else begin
            bus.tbl_we = 1'b0;
        end
        bus.upd_ready = !rst || !full_s;
        init_busy     = !rst || (state_r == ST_INIT);
        mispred       = mispred_s;
        mispred_cnt   = cnt_r;
    end

    // Control FSM: walk every PHT entry in INIT, then stay in RUN until clr
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            state_r <= ST_INIT;
            walk_r  <= {IW{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (walk_r == {IW{1'b1}}) begin
                        state_r <= ST_RUN;
                        walk_r  <= {IW{1'b0}};
                    end else begin
                        walk_r  <= walk_r + IW'(1);
                    end
                end
                ST_RUN: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r <= ST_INIT;
                    walk_r  <= {IW{1'b0}};
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; clr discards everything queued
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; payload needs no reset since occupancy guards it
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_row_r[wr_ptr_r]   <= bus.upd_row;
            q_col_r[wr_ptr_r]   <= bus.upd_col;
            q_state_r[wr_ptr_r] <= bus.upd_state;
            q_br_r[wr_ptr_r]    <= bus.upd_br_en;
        end
    end

    // Bypass register holds only the write of the immediately preceding cycle
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            byp_valid_r <= 1'b0;
            byp_row_r   <= {S_ROW_IDX{1'b0}};
            byp_col_r   <= {S_GBHR{1'b0}};
            byp_val_r   <= 2'd0;
        end else if (pop_s) begin
            byp_valid_r <= 1'b1;
            byp_row_r   <= hd_row_s;
            byp_col_r   <= hd_col_s;
            byp_val_r   <= run_wdata_s;
        end else begin
            byp_valid_r <= 1'b0;
        end
    end

    // Saturating misprediction counter; survives clr, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= 16'd0;
        end else if (mispred_s && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched: expected PHT writes are queued when an
// update is offered and compared against the DUT on every drained write.
module tb_bp_update_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        init_busy;
    logic        mispred;
    logic [15:0] mispred_cnt;

    bp_update_sched_if #(.S_ROW_IDX(4), .S_GBHR(4)) bus ();

    bp_update_sched #(.S_ROW_IDX(4), .S_GBHR(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .bus         (bus),
        .init_busy   (init_busy),
        .mispred     (mispred),
        .mispred_cnt (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
        logic [1:0] wdata;
        logic       mis;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   misp_total = 0;
    int   misp_base  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
        int d;
        d = misp_total - misp_base;
        return (d > 65535) ? 16'hFFFF : 16'(d);
    endfunction

    // Advance to the next falling edge and score any RUN-phase PHT write
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (rst && bus.tbl_we && !init_busy) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("sb_write", {bus.tbl_row, bus.tbl_col, bus.tbl_wdata, mispred}, e);
                if (e.mis) misp_total++;
            end
        end else if (rst) begin
            chk("mispred_quiet", mispred, 1'b0);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] r, input logic [3:0] c,
                         input logic [1:0] s, input logic b);
        bus.upd_valid = v;
        bus.upd_row   = r;
        bus.upd_col   = c;
        bus.upd_state = s;
        bus.upd_br_en = b;
    endtask

    task automatic expect_wr(input logic [3:0] r, input logic [3:0] c,
                             input logic [1:0] wd, input logic m);
        exp_t e;
        e.row = r; e.col = c; e.wdata = wd; e.mis = m;
        sb.push_back(e);
    endtask

    task automatic walk_check(input int i);
        logic [7:0] a;
        a = 8'(i);
        chk("init_walk", {init_busy, bus.tbl_we, bus.tbl_row, bus.tbl_col, bus.tbl_wdata, mispred},
            {1'b1, 1'b1, a, 2'd1, 1'b0});
    endtask

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);

        // Reset behaviour
        cyc();
        cyc();
        chk("rst_ready", bus.upd_ready, 1'b1);
        chk("rst_busy", init_busy, 1'b1);
        chk("rst_we", bus.tbl_we, 1'b0);
        chk("rst_mispred", mispred, 1'b0);
        chk("rst_cnt", mispred_cnt, 16'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Full initialization walk after reset
        for (int i = 0; i < 256; i++) begin
            cyc();
            walk_check(i);
        end
        cyc();
        chk("init_done_busy", init_busy, 1'b0);
        chk("init_done_we", bus.tbl_we, 1'b0);

        // Single mispredicting update
        drive(1'b1, 4'd3, 4'd5, 2'd2, 1'b0);
        expect_wr(4'd3, 4'd5, 2'd1, 1'b1);
        cyc();
        chk("single_latency", bus.tbl_we, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
        cyc();
        chk("single_cnt", mispred_cnt, 16'd1);

        // Back-to-back same address (bypass), saturation, idle invalidation
        drive(1'b1, 4'd2, 4'd0, 2'd1, 1'b1);
        expect_wr(4'd2, 4'd0, 2'd2, 1'b1);
        cyc();
        drive(1'b1, 4'd2, 4'd0, 2'd1, 1'b1);
        expect_wr(4'd2, 4'd0, 2'd3, 1'b0);
        cyc();
        drive(1'b1, 4'd7, 4'd9, 2'd3, 1'b1);
        expect_wr(4'd7, 4'd9, 2'd3, 1'b0);
        cyc();
        drive(1'b1, 4'd1, 4'd1, 2'd0, 1'b0);
        expect_wr(4'd1, 4'd1, 2'd0, 1'b0);
        cyc();
        drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
        cyc();
        cyc();
        drive(1'b1, 4'd2, 4'd0, 2'd1, 1'b1);
        expect_wr(4'd2, 4'd0, 2'd2, 1'b1);
        cyc();
        drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
        cyc();
        chk("b2b_cnt", mispred_cnt, 16'd3);

        // clr restarts INIT; entries queued before the final clr are discarded
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 256; i++) begin
            walk_check(i);
            if (i >= 1 && i <= 3) begin
                drive(1'b1, 4'(i), 4'(i), 2'd0, 1'b1);
            end else if (i == 4) begin
                drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
            end
            if (i == 255) begin
                clr = 1'b1;
                drive(1'b1, 4'd15, 4'd15, 2'd0, 1'b1);
            end
            cyc();
        end
        clr = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
        chk("clr_cnt_kept", mispred_cnt, exp_cnt());

        // Fill the queue during INIT; fifth update refused; drain after INIT
        for (int i = 0; i < 256; i++) begin
            walk_check(i);
            if (i == 20) begin
                chk("fill_ready0", bus.upd_ready, 1'b1);
                drive(1'b1, 4'd4, 4'd1, 2'd2, 1'b1);
                expect_wr(4'd4, 4'd1, 2'd3, 1'b0);
            end else if (i == 21) begin
                chk("fill_ready1", bus.upd_ready, 1'b1);
                drive(1'b1, 4'd4, 4'd1, 2'd2, 1'b0);
                expect_wr(4'd4, 4'd1, 2'd2, 1'b1);
            end else if (i == 22) begin
                chk("fill_ready2", bus.upd_ready, 1'b1);
                drive(1'b1, 4'd5, 4'd2, 2'd1, 1'b0);
                expect_wr(4'd5, 4'd2, 2'd0, 1'b0);
            end else if (i == 23) begin
                chk("fill_ready3", bus.upd_ready, 1'b1);
                drive(1'b1, 4'd6, 4'd3, 2'd0, 1'b1);
                expect_wr(4'd6, 4'd3, 2'd1, 1'b1);
            end else if (i == 24) begin
                chk("full_ready", bus.upd_ready, 1'b0);
                drive(1'b1, 4'd9, 4'd9, 2'd0, 1'b1);
            end else if (i == 25) begin
                drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
            end
            cyc();
        end
        chk("drain_start_we", bus.tbl_we, 1'b1);
        chk("drain_full_ready", bus.upd_ready, 1'b0);
        cyc();
        chk("drain_freed_ready", bus.upd_ready, 1'b1);
        cyc();
        cyc();
        cyc();
        chk("drain_idle_we", bus.tbl_we, 1'b0);
        cyc();
        chk("drain_cnt", mispred_cnt, exp_cnt());

        // Saturate the misprediction counter with alternating addresses
        for (int k = 0; k < 65540; k++) begin
            if (bus.upd_ready) begin
                drive(1'b1, 4'(k), 4'(k >> 4), 2'd2, 1'b0);
                expect_wr(4'(k), 4'(k >> 4), 2'd1, 1'b1);
            end else begin
                drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
            end
            cyc();
        end
        drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
        cyc();
        cyc();
        cyc();
        chk("sat_cnt", mispred_cnt, 16'hFFFF);
        chk("sat_cnt_model", mispred_cnt, exp_cnt());
        drive(1'b1, 4'd3, 4'd3, 2'd2, 1'b0);
        expect_wr(4'd3, 4'd3, 2'd1, 1'b1);
        cyc();
        chk("sat_pulse", mispred, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
        cyc();
        chk("sat_hold", mispred_cnt, 16'hFFFF);

        // Reset in the middle of INIT with entries queued
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 50; i++) begin
            walk_check(i);
            if (i == 5 || i == 6) begin
                drive(1'b1, 4'd8, 4'(i), 2'd0, 1'b1);
            end else if (i == 7) begin
                drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
            end
            cyc();
        end
        rst = 1'b0;
        cyc();
        chk("rst2_ready", bus.upd_ready, 1'b1);
        chk("rst2_busy", init_busy, 1'b1);
        chk("rst2_we", bus.tbl_we, 1'b0);
        chk("rst2_cnt", mispred_cnt, 16'd0);
        misp_base = misp_total;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cyc();
            walk_check(i);
        end
        cyc();
        chk("rst2_done_busy", init_busy, 1'b0);
        cyc();
        chk("rst2_cnt_after", mispred_cnt, exp_cnt());
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_update_sched.md
BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

Interface
REQ-001 Parameter S_ROW_IDX, default 4, PHT row index width.
REQ-002 Parameter S_GBHR, default 4, history width; PHT column index width.
REQ-003 Parameter DEPTH, default 4, update-queue entries, power of 2, >=2.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset (asserted when 0).
REQ-006 clr  in  1  request table re-initialization; single-cycle pulse.
REQ-007 upd_valid  in  1  resolved branch update offered.
REQ-008 upd_row  in  S_ROW_IDX  PHT row of the branch.
REQ-009 upd_col  in  S_GBHR  history value used at prediction.
REQ-010 upd_state  in  2  counter read at prediction (0 sn, 1 wn, 2 wt, 3 st).
REQ-011 upd_br_en  in  1  actual branch outcome.
REQ-012 upd_ready  out  1  queue can accept this cycle.
REQ-013 tbl_we  out  1  PHT write strobe.
REQ-014 tbl_row / tbl_col  out  S_ROW_IDX / S_GBHR  PHT write address.
REQ-015 tbl_wdata  out  2  PHT write value.
REQ-016 init_busy  out  1  table initialization in progress.
REQ-017 mispred  out  1  one-cycle pulse per drained misprediction.
REQ-018 mispred_cnt  out  16  saturating misprediction count.

Function
REQ-019 FSM states INIT and RUN; INIT walks all 2^(S_ROW_IDX+S_GBHR) entries, one per cycle, row-major (col fastest), tbl_we=1, tbl_wdata=1 (wn).
REQ-020 INIT -> RUN on the cycle after the write to the last entry (row and col all ones); init_busy=1 exactly while in INIT.
REQ-021 clr=1 in any state: next cycle INIT with walk index 0, queue emptied, bypass register invalidated, mispred_cnt unchanged.
REQ-022 Queue is FIFO of {row, col, state, br_en}; push when upd_valid && upd_ready; upd_ready = !full, in both states, independent of same-cycle pop.
REQ-023 clr has priority over push: an update offered in the clr cycle is dropped.
REQ-024 In RUN with queue non-empty: head popped each cycle; tbl_we=1, tbl_row/tbl_col = head address; outputs combinational from head.
REQ-025 No pop in INIT; entries accepted during INIT wait and drain in order after INIT.
REQ-026 Latency: update accepted at edge t into empty queue in RUN -> tbl_we in the cycle following edge t; DEPTH back-to-back updates drain at one per cycle.
REQ-027 Base counter = upd_state of head, unless bypass register valid with matching row and col, then base = bypass value.
REQ-028 tbl_wdata = base+1 saturating at 3 if br_en, else base-1 saturating at 0.
REQ-029 Bypass register loads {row, col, tbl_wdata} on every RUN pop; invalidated on reset, clr, and any idle cycle (no pop).
REQ-030 mispred = tbl_we in RUN && (base[1] != br_en); INIT writes never raise mispred.
REQ-031 mispred_cnt increments on each mispred pulse; holds at 0xFFFF.
REQ-032 Full and push-blocked: upd_ready=0 until a pop frees an entry; the following cycle upd_ready=1.
REQ-033 Pointers wrap modulo DEPTH; count width log2(DEPTH)+1 distinguishes full from empty.

Reset
REQ-034 rst=0 at a clock edge: state INIT, walk index 0, queue empty, bypass invalid, mispred_cnt=0, mispred=0.
REQ-035 During reset cycle and first cycle after: upd_ready=1, init_busy=1, tbl_we=1 only from first INIT cycle at address (0,0).
REQ-036 Reset mid-INIT or mid-drain: walk restarts at (0,0), queued entries discarded.

Verification
REQ-037 Reset release, defaults -> 256 consecutive tbl_we with wdata=1 addresses (0,0)..(15,15), then init_busy=0, tbl_we=0.
REQ-038 RUN, single update row=3 col=5 state=2 br_en=0 -> next cycle tbl_we=1, (3,5), wdata=1, mispred=1, mispred_cnt=1.
REQ-039 RUN, two back-to-back updates row=2 col=0 state=1 br_en=1 -> writes wdata=2 then wdata=3 (bypass), mispred then no mispred.
REQ-040 During INIT push 5 updates -> first 4 accepted, upd_ready=0 on fifth, drain in order starting cycle after INIT ends.
REQ-041 clr asserted with 3 queued entries in RUN -> queue empty, INIT restarts at (0,0), none of the 3 written, mispred_cnt unchanged.
REQ-042 Force mispred_cnt to 0xFFFF via 65535+ mispredicting updates -> further mispred pulses leave count at 0xFFFF.
